subckt_pattern_sequencer: RTL and testbench
===========================================

// Module: subckt_pattern_sequencer
// PURPOSE
//   Exhaustive pattern sequencer for a small Nt-node sequential subcircuit.
//   - Drives one pattern bus to a suspect instance and a golden instance.
//   - Holds each pattern until the pipeline settles, then compares both responses.
//   - Reports mismatch count, first failing pattern and a sticky fail flag.
//   - Sits between the bench/top-level test controller and the subcircuit pair.
// PARAMETERS
//   N_IN     3   width of pattern bus (subcircuit primary inputs); 2**N_IN patterns per run
//   LATENCY  3   settle cycles per pattern (DFF depth, input to output)
//   CNT_W    8   width of mismatch counter
// PORTS
//   I1470_clk       in   1       single clock, all flops rising-edge
//   I1477_rst       in   1       reset, synchronous, active-high
//   start           in   1       run request, sampled in IDLE only
//   abort           in   1       terminate run, sampled in SETTLE/COMPARE
//   pat_out         out  N_IN    pattern to both subcircuit instances
//   pat_valid       out  1       high while pat_out is being applied (SETTLE, COMPARE)
//   dut_resp        in   1       suspect instance output
//   gold_resp       in   1       golden instance output
//   busy            out  1       high in SETTLE/COMPARE/DONE
//   done            out  1       one-cycle pulse at normal run completion
//   fail            out  1       sticky: at least one mismatch in current/last run
//   mismatch_cnt    out  CNT_W   mismatching patterns, saturating
//   first_fail_pat  out  N_IN    pattern of first mismatch; 0 if none
// BEHAVIOUR
//   Reset (I1477_rst=1 at clock edge): state=IDLE.
//     - pat_out=0, pat_valid=0, busy=0, done=0, fail=0, mismatch_cnt=0, first_fail_pat=0.
//     - Internal counters are cleared.
//     - Overrides everything, including mid-run.
//   FSM: IDLE -> SETTLE -> COMPARE -> (SETTLE | DONE) -> IDLE.
//   IDLE: on start=1, clear fail, mismatch_cnt, first_fail_pat and pat_out, then go to SETTLE.
//   SETTLE: hold pat_out for exactly LATENCY cycles, no comparison, then go to COMPARE.
//   COMPARE (1 cycle): sample dut_resp and gold_resp.
//     - On mismatch: mismatch_cnt +1, held at 2**CNT_W-1 once reached.
//     - On the first mismatch of the run, first_fail_pat=pat_out and fail=1.
//     - If pat_out == 2**N_IN-1, go to DONE. Else pat_out+1 and go to SETTLE.
//   DONE (1 cycle): done=1, then IDLE. Results hold until the next start or reset.
//   Per-pattern cost is LATENCY+1 cycles.
//     - Defaults: done is asserted 8*4+1 = 33 cycles after the start edge.
//   abort=1 in SETTLE/COMPARE: go to IDLE next cycle.
//     - No done pulse; the COMPARE in that cycle is not counted.
//     - Results so far are retained; pat_out and pat_valid go to 0.
//   start while busy is ignored. abort in IDLE/DONE is ignored.
//   start and abort together in IDLE: start wins.
//   pat_out never wraps inside a run. The run ends at the all-ones pattern.
//   Outputs are registered, with no combinational path from inputs to outputs.
// CONFIGURATION
//   PAT_MISR_EN defined:
//     - Adds output sig[15:0], a 16-bit MISR with polynomial x^16+x^12+x^3+x+1.
//     - Seed 16'hFFFF, reloaded on reset and on an accepted start.
//     - Each COMPARE shifts in dut_resp XOR'd into bit 0.
//     - Value is held outside COMPARE.
//   PAT_MISR_EN undefined: the sig port and its logic are absent. All other behaviour is identical.
// TESTING
//   1. Reset, gold_resp==dut_resp for all patterns, pulse start.
//      -> done at cycle 33, fail=0, mismatch_cnt=0.
//   2. Force dut_resp!=gold_resp only while pat_out==3'b101.
//      -> mismatch_cnt=1, first_fail_pat=3'b101, fail=1.
//   3. Invert dut_resp always, with CNT_W=2.
//      -> mismatch_cnt saturates at 3, first_fail_pat=0.
//   4. start, then abort in the 3rd COMPARE.
//      -> IDLE next cycle, no done, mismatch_cnt reflects only 2 compares.
//   5. Assert I1477_rst during SETTLE of pattern 4.
//      -> all outputs 0 at next edge. A new start runs a full 33-cycle pass.
//   6. PAT_MISR_EN, identical-response run twice.
//      -> same sig both runs. A single flipped response -> different sig.

Source files
------------

// File: rtl/subckt_pattern_sequencer_if.sv
// Handshake bundle between the test controller, the pattern sequencer and the subcircuit pair.
// The sig signature port exists only when PAT_MISR_EN is defined.
interface subckt_pattern_sequencer_if #(
    parameter int N_IN  = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  pat_out;
    logic             pat_valid;
    logic             dut_resp;
    logic             gold_resp;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [N_IN-1:0]  first_fail_pat;
`ifdef PAT_MISR_EN
    logic [15:0]      sig;

    modport master (
        output start, abort, dut_resp, gold_resp,
        input  pat_out, pat_valid, busy, done, fail, mismatch_cnt, first_fail_pat, sig
    );
    modport slave (
        input  start, abort, dut_resp, gold_resp,
        output pat_out, pat_valid, busy, done, fail, mismatch_cnt, first_fail_pat, sig
    );
`else
    modport master (
        output start, abort, dut_resp, gold_resp,
        input  pat_out, pat_valid, busy, done, fail, mismatch_cnt, first_fail_pat
    );
    modport slave (
        input  start, abort, dut_resp, gold_resp,
        output pat_out, pat_valid, busy, done, fail, mismatch_cnt, first_fail_pat
    );
`endif
endinterface

// File: rtl/subckt_pattern_sequencer.sv
// Exhaustive pattern sequencer: applies every N_IN-bit pattern, waits LATENCY cycles, compares suspect vs golden.
// Optional feature macro PAT_MISR_EN adds a 16-bit MISR signature of the suspect responses.
module subckt_pattern_sequencer #(
    parameter int N_IN    = 3,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 8
) (
    input  logic                     I1470_clk,
    input  logic                     I1477_rst,
    subckt_pattern_sequencer_if.slave bus
);
    localparam int               SET_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LATENCY - 1);
    localparam logic [N_IN-1:0]  PAT_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [SET_W-1:0] r_settle, w_settle_nxt;
    logic [N_IN-1:0]  r_pat, w_pat_nxt;
    logic             r_fail, w_fail_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_IN-1:0]  r_first, w_first_nxt;
    logic             r_pat_valid, r_busy, r_done;
    logic             w_mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

`ifdef PAT_MISR_EN
    logic [15:0] r_sig, w_sig_nxt;

    // x^16 + x^12 + x^3 + x + 1, new response folded into bit 0
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        logic [15:0] n;
        n    = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000);
        n[0] = n[0] ^ d;
        return n;
    endfunction
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_pat_nxt    = r_pat;
        w_fail_nxt   = r_fail;
        w_cnt_nxt    = r_cnt;
        w_first_nxt  = r_first;
        w_mismatch   = bus.dut_resp ^ bus.gold_resp;
`ifdef PAT_MISR_EN
        w_sig_nxt    = r_sig;
`endif
        case (r_state)
            S_IDLE: begin
                // start beats a simultaneous abort: abort is not looked at here
                if (bus.start) begin
                    w_state_nxt  = S_SETTLE;
                    w_settle_nxt = '0;
                    w_pat_nxt    = '0;
                    w_fail_nxt   = 1'b0;
                    w_cnt_nxt    = '0;
                    w_first_nxt  = '0;
`ifdef PAT_MISR_EN
                    w_sig_nxt    = 16'hFFFF;
`endif
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_pat_nxt   = '0;
                end else if (r_settle == SET_LAST) begin
                    w_state_nxt  = S_COMPARE;
                    w_settle_nxt = '0;
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end
            S_COMPARE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_pat_nxt   = '0;
                end else begin
                    if (w_mismatch) begin
                        w_cnt_nxt = sat_inc(r_cnt);
                        if (!r_fail) begin
                            w_fail_nxt  = 1'b1;
                            w_first_nxt = r_pat;
                        end
                    end
`ifdef PAT_MISR_EN
                    w_sig_nxt = misr_step(r_sig, bus.dut_resp);
`endif
                    if (r_pat == PAT_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pat_nxt   = r_pat + N_IN'(1);
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_pat       <= '0;
            r_fail      <= 1'b0;
            r_cnt       <= '0;
            r_first     <= '0;
            r_pat_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PAT_MISR_EN
            r_sig       <= 16'hFFFF;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_settle    <= w_settle_nxt;
            r_pat       <= w_pat_nxt;
            r_fail      <= w_fail_nxt;
            r_cnt       <= w_cnt_nxt;
            r_first     <= w_first_nxt;
            r_pat_valid <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_COMPARE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
`ifdef PAT_MISR_EN
            r_sig       <= w_sig_nxt;
`endif
        end
    end

    assign bus.pat_out        = r_pat;
    assign bus.pat_valid      = r_pat_valid;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.fail           = r_fail;
    assign bus.mismatch_cnt   = r_cnt;
    assign bus.first_fail_pat = r_first;
`ifdef PAT_MISR_EN
    assign bus.sig            = r_sig;
`endif
endmodule

// File: tb/tb_subckt_pattern_sequencer.sv
// Scoreboard bench for subckt_pattern_sequencer: expected run results queued at start, checked at run end.
// Instance uses CNT_W=2 so counter saturation is reachable within one 8-pattern run.
module tb_subckt_pattern_sequencer;
    localparam int N_IN    = 3;
    localparam int LATENCY = 3;
    localparam int CNT_W   = 2;
    localparam int NPAT    = 1 << N_IN;
    localparam int PER     = LATENCY + 1;
    localparam int RUN_CYC = NPAT * PER + 1;

    logic clk = 1'b0;
    logic rst;
    logic [NPAT-1:0] fault_mask;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int fail;
        int cnt;
        int first;
    } res_t;
    res_t sb_q[$];

    subckt_pattern_sequencer_if #(.N_IN(N_IN), .CNT_W(CNT_W)) bus ();

    subckt_pattern_sequencer #(.N_IN(N_IN), .LATENCY(LATENCY), .CNT_W(CNT_W)) u_dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // Subcircuit pair model: golden is parity of the pattern, suspect flips where fault_mask is set
    always_comb begin
        bus.gold_resp = ^bus.pat_out;
        bus.dut_resp  = (^bus.pat_out) ^ fault_mask[bus.pat_out];
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [NPAT-1:0] m, input int n_cmp);
        res_t r;
        r.fail = 0; r.cnt = 0; r.first = 0;
        for (int p = 0; p < n_cmp; p++) begin
            if (m[p]) begin
                if (r.fail == 0) begin
                    r.fail  = 1;
                    r.first = p;
                end
                if (r.cnt < (1 << CNT_W) - 1) r.cnt++;
            end
        end
        return r;
    endfunction

`ifdef PAT_MISR_EN
    function automatic logic [15:0] misr_model(input logic [NPAT-1:0] m);
        logic [15:0] s;
        logic [N_IN-1:0] pv;
        logic d;
        s = 16'hFFFF;
        for (int p = 0; p < NPAT; p++) begin
            pv = N_IN'(p);
            d  = (^pv) ^ m[p];
            s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000);
            s[0] = s[0] ^ d;
        end
        return s;
    endfunction
`endif

    task automatic pop_and_compare(input string tag);
        res_t e;
        check({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_fail"},  bus.fail,           e.fail);
            check({tag, "_cnt"},   bus.mismatch_cnt,   e.cnt);
            check({tag, "_first"}, bus.first_fail_pat, e.first);
        end
    endtask

    // abort_k: abort during the k-th COMPARE (0 = none); stray_start: cycle to pulse start while busy
    task automatic run(input string tag, input logic [NPAT-1:0] m, input int abort_k,
                       input int stray_start, input bit with_abort);
        int n_done;
        int done_cyc;
        fault_mask = m;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = with_abort;
        sb_q.push_back(model(m, (abort_k != 0) ? abort_k - 1 : NPAT));
        n_done   = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= RUN_CYC + 8; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (cyc == 1) check({tag, "_busy_c1"}, bus.busy, 1);
            if (abort_k == 0 && cyc % PER == 0 && cyc < RUN_CYC) begin
                check({tag, "_pat"}, bus.pat_out, cyc / PER - 1);
                check({tag, "_pvld"}, bus.pat_valid, 1);
            end
            if (bus.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (abort_k != 0 && cyc == abort_k * PER) bus.abort = 1'b1;
            if (abort_k != 0 && cyc == abort_k * PER + 1) begin
                check({tag, "_abort_busy"}, bus.busy, 0);
                check({tag, "_abort_pvld"}, bus.pat_valid, 0);
                check({tag, "_abort_pat"},  bus.pat_out, 0);
            end
            if (cyc == stray_start) bus.start = 1'b1;
        end
        if (abort_k == 0) begin
            check({tag, "_done_cyc"}, done_cyc, RUN_CYC);
            check({tag, "_done_cnt"}, n_done, 1);
        end else begin
            check({tag, "_no_done"}, n_done, 0);
        end
        check({tag, "_idle_busy"}, bus.busy, 0);
        pop_and_compare(tag);
    endtask

    task automatic reset_mid_run(input logic [NPAT-1:0] m);
        res_t dropped;
        fault_mask = m;
        @(negedge clk);
        bus.start = 1'b1;
        sb_q.push_back(model(m, NPAT));
        @(negedge clk);
        bus.start = 1'b0;
        // now in cycle 1; advance to cycle 17, first SETTLE cycle of pattern 4
        repeat (4 * PER) @(negedge clk);
        check("rst_pre_pat",  bus.pat_out, 4);
        check("rst_pre_fail", bus.fail, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_pat",   bus.pat_out, 0);
        check("rst_mid_pvld",  bus.pat_valid, 0);
        check("rst_mid_busy",  bus.busy, 0);
        check("rst_mid_done",  bus.done, 0);
        check("rst_mid_fail",  bus.fail, 0);
        check("rst_mid_cnt",   bus.mismatch_cnt, 0);
        check("rst_mid_first", bus.first_fail_pat, 0);
        if (sb_q.size() > 0) dropped = sb_q.pop_front();
    endtask

    initial begin
`ifdef PAT_MISR_EN
        logic [15:0] s1, s2, s3;
`endif
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        fault_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_pat",   bus.pat_out, 0);
        check("reset_pvld",  bus.pat_valid, 0);
        check("reset_busy",  bus.busy, 0);
        check("reset_done",  bus.done, 0);
        check("reset_fail",  bus.fail, 0);
        check("reset_cnt",   bus.mismatch_cnt, 0);
        check("reset_first", bus.first_fail_pat, 0);

        run("clean", '0, 0, 10, 1'b0);
        run("fault5", NPAT'(1) << 5, 0, 0, 1'b0);
        run("invert", '1, 0, 0, 1'b0);
        run("abort3", '1, 3, 0, 1'b0);
        run("start_abort", NPAT'(1) << 2, 0, 0, 1'b1);
        reset_mid_run(NPAT'(1) << 1);
        run("after_rst", '0, 0, 0, 1'b0);

`ifdef PAT_MISR_EN
        run("misr_a", '0, 0, 0, 1'b0);
        s1 = bus.sig;
        run("misr_b", '0, 0, 0, 1'b0);
        s2 = bus.sig;
        run("misr_c", NPAT'(1) << 3, 0, 0, 1'b0);
        s3 = bus.sig;
        check("misr_clean_val", s1, misr_model('0));
        check("misr_repeat",    s2, s1);
        check("misr_flip_val",  s3, misr_model(NPAT'(1) << 3));
        check("misr_differs",   (s3 != s1) ? 1 : 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
